// File: rtl/frame_sched.sv
// Frame scheduler: on each frame tick runs erase -> move -> draw of the platform,
// gating the drawer's pixel writes onto the VGA adapter and flagging late ticks.
module frame_sched #(
    parameter int TICK_CYCLES = 833333,
    parameter int DRAW_CYCLES = 24
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pause,
    input  logic [9:0] in_x,
    input  logic [9:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       in_wren,
    output logic       enable,
    output logic       draw,
    output logic [9:0] vga_x,
    output logic [9:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_wren,
    output logic       frame_done,
    output logic       overrun
);

    localparam int WW = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(DRAW_CYCLES - 1);
    localparam logic [19:0]   TICK_LAST = 20'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ERASE_START,
        ERASE_WAIT,
        MOVE,
        DRAW_START,
        DRAW_WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] tick_cnt_q, tick_cnt_d;
    logic [WW-1:0] win_q, win_d;
    logic        overrun_q, overrun_d;
    logic [9:0]  vga_x_q, vga_x_d, vga_y_q, vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;
    logic        vga_wren_q, vga_wren_d;

    logic tick;
    logic window;
    logic erase;

    assign tick   = (tick_cnt_q == TICK_LAST);
    assign erase  = (state_q == ERASE_START) || (state_q == ERASE_WAIT);
    assign window = erase || (state_q == DRAW_START) || (state_q == DRAW_WAIT);

    always_comb begin
        state_d      = state_q;
        win_d        = '0;
        tick_cnt_d   = tick ? 20'd0 : tick_cnt_q + 20'd1;
        // A tick outside IDLE (including DONE) is dropped and remembered.
        overrun_d    = overrun_q | (tick && (state_q != IDLE));
        vga_x_d      = in_x;
        vga_y_d      = in_y;
        vga_wren_d   = in_wren & window;
        vga_colour_d = erase ? 3'b000 : in_colour;

        case (state_q)
            IDLE:        if (tick && !pause) state_d = ERASE_START;
            ERASE_START: state_d = ERASE_WAIT;
            ERASE_WAIT: begin
                if (win_q == WIN_LAST) state_d = MOVE;
                else                   win_d   = win_q + 1'b1;
            end
            MOVE:        state_d = DRAW_START;
            DRAW_START:  state_d = DRAW_WAIT;
            DRAW_WAIT: begin
                if (win_q == WIN_LAST) state_d = DONE;
                else                   win_d   = win_q + 1'b1;
            end
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            win_q        <= '0;
            overrun_q    <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_wren_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            win_q        <= win_d;
            overrun_q    <= overrun_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_wren_q   <= vga_wren_d;
        end
    end

    // Pulses decode straight from the state register, so reset clears them at once.
    assign draw       = (state_q == ERASE_START) || (state_q == DRAW_START);
    assign enable     = (state_q == MOVE);
    assign frame_done = (state_q == DONE);
    assign overrun    = overrun_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_wren   = vga_wren_q;

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 833333, meaning clocks per frame tick (50 MHz / 60 Hz); legal range 16..1048575.
REQ-002 SHALL have parameter DRAW_CYCLES, default 24, meaning length of each pixel-write window in clocks; SHALL be at least platform size + 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pause, input, 1 bit: while high, suppresses start of new frames.
REQ-006 SHALL have ports in_x and in_y, each input, 10 bits: pixel coordinate from the platform drawer.
REQ-007 SHALL have port in_colour, input, 3 bits: pixel colour from the platform drawer.
REQ-008 SHALL have port in_wren, input, 1 bit: write request from the platform drawer.
REQ-009 SHALL have port enable, output, 1 bit: one-cycle move-step pulse to the platform.
REQ-010 SHALL have port draw, output, 1 bit: one-cycle draw-start pulse to the platform.
REQ-011 SHALL have ports vga_x and vga_y (each output, 10 bits), vga_colour (output, 3 bits) and vga_wren (output, 1 bit): pixel write to the VGA adapter.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, tick arrived while a frame was in progress.

Function
REQ-014 SHALL run a 20-bit tick counter from 0 to TICK_CYCLES-1 and then wrap to 0; tick = (counter == TICK_CYCLES-1).
REQ-015 SHALL implement the states IDLE, ERASE_START, ERASE_WAIT, MOVE, DRAW_START, DRAW_WAIT and DONE.
REQ-016 IDLE SHALL go to ERASE_START on the cycle after tick when pause=0; otherwise it SHALL stay in IDLE.
REQ-017 ERASE_START SHALL assert draw for 1 cycle and then go to ERASE_WAIT.
REQ-018 ERASE_WAIT SHALL last exactly DRAW_CYCLES cycles, counted by a window counter, and then go to MOVE.
REQ-019 MOVE SHALL assert enable for 1 cycle and then go to DRAW_START.
REQ-020 DRAW_START SHALL assert draw for 1 cycle and then go to DRAW_WAIT.
REQ-021 DRAW_WAIT SHALL last exactly DRAW_CYCLES cycles and then go to DONE.
REQ-022 DONE SHALL assert frame_done for 1 cycle and then go to IDLE.
REQ-023 Total frame length SHALL be 2*DRAW_CYCLES+4 cycles; TICK_CYCLES SHALL exceed this value.
REQ-024 The write window SHALL be open in ERASE_START, ERASE_WAIT, DRAW_START and DRAW_WAIT.
REQ-025 vga_wren SHALL be in_wren gated by the write window, registered with 1-cycle latency.
REQ-026 Outside the write window vga_wren SHALL be 0 regardless of in_wren, because the drawer holds wren high while idle.
REQ-027 vga_x and vga_y SHALL be in_x and in_y registered with 1-cycle latency, unmodified.
REQ-028 vga_colour SHALL be 3'b000 (black) for writes in the erase phase (ERASE_START, ERASE_WAIT), otherwise in_colour, registered with 1-cycle latency.
REQ-029 A tick arriving in any state other than IDLE SHALL be dropped and SHALL set overrun to 1.
REQ-030 overrun SHALL stay 1 until reset.
REQ-031 Rising pause mid-frame SHALL NOT abort the frame; the frame SHALL complete and the FSM SHALL then hold in IDLE.
REQ-032 A tick coinciding with DONE SHALL count as overrun, since the state is not IDLE.
REQ-033 enable, draw and frame_done SHALL be mutually exclusive and SHALL never be high for 2 consecutive cycles.

Reset
REQ-034 resetn low SHALL immediately force state=IDLE, tick counter=0, window counter=0, overrun=0, and enable, draw, frame_done, vga_wren=0, vga_x=vga_y=0, vga_colour=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no further pulses.
REQ-036 After reset release the first tick SHALL occur TICK_CYCLES clocks later.

Verification
REQ-037 Frame sequence: TICK_CYCLES=40, DRAW_CYCLES=5, pause=0 -> draw at cycle 40, enable at 46, draw at 47, frame_done at 53, next draw at 80.
REQ-038 Erase colouring: in_wren=1, in_colour=3'b100 held constant -> vga_wren=1 with vga_colour=000 for cycles 41-46 and with colour 100 for cycles 48-53; vga_wren=0 at all other times.
REQ-039 Pause: pause=1 held across cycles 30-100 -> no draw, enable or frame_done pulses, overrun stays 0; after release the frame starts at the next tick (cycle 120).
REQ-040 Overrun: TICK_CYCLES=16, DRAW_CYCLES=8 (frame length 20) -> second tick lands in DRAW_WAIT, overrun=1 and stays 1; no frame restarts mid-frame.
REQ-041 Reset mid-frame: resetn low at cycle 44 for 2 cycles -> all outputs 0 at once, no enable pulse; after release the next draw occurs 40 cycles later.
